addsub_arbiter: RTL and testbench
=================================

# addsub_arbiter

Shares one WIDTH-bit add/subtract unit between two requesters. Each requester uses a valid/ready handshake; the block grants one request per cycle with round-robin priority. The result is held in a single-entry output register with valid/ready back-pressure and a requester ID tag. It sits between the request sources and the combinational add/sub datapath, and is the only block that drives that datapath.

## Interface
Parameters:
- WIDTH, 8, operand and result width

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  2  per-requester request valid (bit i = requester i)
- in_ready  output  2  per-requester accept; a transfer occurs when in_valid[i] && in_ready[i]
- in_a  input  2×WIDTH  per-requester operand A
- in_b  input  2×WIDTH  per-requester operand B
- in_sel  input  2  per-requester op: 1 = A+B, 0 = A−B
- out_valid  output  1  result register holds a valid result
- out_ready  input  1  consumer accepts the result
- out_data  output  WIDTH  result, mod 2^WIDTH
- out_carry  output  1  carry-out for add; borrow (A<B, unsigned) for subtract
- out_id  output  1  index of the requester that produced out_data

Decided: one clock; reset is asynchronous and active-high (clk, rst).

## Operation
- States:
  - EMPTY: output register free.
  - FULL: output register holds an unconsumed result.
- Accept condition: `can_accept = EMPTY || (FULL && out_ready)`.
- Grant:
  - in_ready[i] = can_accept && grant[i]. At most one bit of in_ready is high.
  - If only one requester is valid, it is granted.
  - If both are valid, the requester other than `last` is granted.
- `last`:
  - Updates to the granted index on every accepted transfer.
  - Reset value is 1, so requester 0 wins the first tie.
  - Does not change on cycles with no transfer.
- Arithmetic:
  - Operands are zero-extended to WIDTH+1 bits.
  - Add: {carry,data} = A+B.
  - Subtract: {borrow,data} = A−B (two's complement wrap).
- On an accepted transfer, the register loads data, carry and id and goes to or stays in FULL.
- FULL && out_ready with no new transfer → EMPTY.
- Registered outputs hold their value while FULL && !out_ready.
- in_ready depends on in_valid, `last`, state and out_ready. There is no combinational path from in_a, in_b or in_sel to in_ready.

## Timing
- Reset (asynchronous, takes effect immediately):
  - state = EMPTY
  - out_valid = 0, out_data = 0, out_carry = 0, out_id = 0
  - last = 1
  - in_ready = 0 while rst is high
- Latency: a request accepted at edge N gives out_valid = 1 after edge N with the result. The consumer can take it at edge N+1.
- Throughput: one result per cycle when out_ready is held high. Accept and drain happen at the same edge.
- Back-pressure: FULL && !out_ready forces in_ready = 0 for both requesters.
- Requester rules:
  - A requester must hold its in_valid and operands stable until accepted.
  - A requester that is not granted keeps waiting with no loss of its request.
- Reset mid-operation: a pending result is discarded and no handshake completes on that cycle.
- Simultaneous requests with both held continuously: grants alternate 0,1,0,1…

## Structure
- Package `addsub_pkg`:
  - WIDTH_DEFAULT = 8
  - typedef `op_e` (OP_SUB = 0, OP_ADD = 1)
  - typedef `state_e` (EMPTY, FULL)
  - typedef `req_t` struct {a, b, op}
- Sub-module `addsub_unit`: combinational; inputs a, b, sel; outputs data and carry. Instantiated once.
- The arbiter and the output register live in the top module.

## Test plan
- Single request: req0 A=3, B=4, add, out_ready=1 → out_data=7, carry=0, id=0 one cycle after accept; in_ready[0]=1 in the accept cycle.
- Wrap and borrow:
  - A=200, B=100, add → out_data=44, carry=1.
  - A=5, B=10, subtract → out_data=251, carry=1.
  - A=10, B=5, subtract → out_data=5, carry=0.
- Round-robin: both requesters valid for 4 cycles with out_ready=1 → out_id sequence 0,1,0,1; neither request lost.
- Back-pressure:
  - Result pending with out_ready=0 for 3 cycles → in_ready=00 and out_data stable.
  - out_ready then rises → the next grant occurs in the same cycle.
- Reset mid-operation: assert rst while FULL with req1 valid → out_valid drops immediately. After release, a tie grants requester 0 first.
- Full throughput: req0 streams 8 back-to-back adds (A=i, B=i) with out_ready=1 → out_data = 0, 2, 4, …, 14 on consecutive cycles with no bubbles.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared types and constants for the add/sub arbiter slice.
package addsub_pkg;

   localparam int unsigned WIDTH_DEFAULT = 8;

   typedef enum logic {
      OP_SUB = 1'b0,
      OP_ADD = 1'b1
   } op_e;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_e;

   // Request bundle at the default width; the top rebuilds it at its own width.
   typedef struct packed {
      logic [WIDTH_DEFAULT-1:0] a;
      logic [WIDTH_DEFAULT-1:0] b;
      op_e                      op;
   } req_t;

endpackage

// File: rtl/addsub_unit.sv
// Combinational WIDTH-bit adder/subtractor with carry (add) or borrow (subtract) out.
module addsub_unit #(
   parameter int unsigned WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sel,
   output logic [WIDTH-1:0] data,
   output logic             carry
);

   // Zero-extend by one bit so the top bit is carry on add and borrow on subtract.
   always_comb begin
      if (sel) begin
         {carry, data} = {1'b0, a} + {1'b0, b};
      end else begin
         {carry, data} = {1'b0, a} - {1'b0, b};
      end
   end

endmodule

// File: rtl/addsub_arbiter.sv
// Round-robin arbiter sharing one add/sub unit between two requesters, with a
// single-entry output register (valid/ready) tagged by requester ID.
module addsub_arbiter
   import addsub_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [1:0]         in_valid,
   output logic [1:0]         in_ready,
   input  logic [2*WIDTH-1:0] in_a,
   input  logic [2*WIDTH-1:0] in_b,
   input  logic [1:0]         in_sel,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_data,
   output logic               out_carry,
   output logic               out_id
);

   typedef struct packed {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      op_e              op;
   } req_w_t;

   state_e           state_q, state_d;
   logic             last_q, last_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             carry_q, carry_d;
   logic             id_q, id_d;

   logic [1:0]       grant;
   logic             gnt_idx;
   logic             can_accept;
   logic             xfer;
   req_w_t           req;
   logic [WIDTH-1:0] alu_data;
   logic             alu_carry;

   // Grant selection: lone requester wins; on a tie the one other than last wins.
   always_comb begin
      grant   = 2'b00;
      gnt_idx = 1'b0;
      case (in_valid)
         2'b01: grant = 2'b01;
         2'b10: begin
            grant   = 2'b10;
            gnt_idx = 1'b1;
         end
         2'b11: begin
            if (last_q) begin
               grant = 2'b01;
            end else begin
               grant   = 2'b10;
               gnt_idx = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Handshake: accept only when the output slot is free or draining this cycle.
   always_comb begin
      can_accept = (state_q == EMPTY) || out_ready;
      in_ready   = (can_accept && !rst) ? grant : 2'b00;
      xfer       = |in_ready;
   end

   // Operand mux for the granted requester.
   always_comb begin
      if (gnt_idx) begin
         req.a  = in_a[2*WIDTH-1:WIDTH];
         req.b  = in_b[2*WIDTH-1:WIDTH];
         req.op = op_e'(in_sel[1]);
      end else begin
         req.a  = in_a[WIDTH-1:0];
         req.b  = in_b[WIDTH-1:0];
         req.op = op_e'(in_sel[0]);
      end
   end

   addsub_unit #(
      .WIDTH (WIDTH)
   ) u_addsub_unit (
      .a     (req.a),
      .b     (req.b),
      .sel   (req.op == OP_ADD),
      .data  (alu_data),
      .carry (alu_carry)
   );

   // Next state: load on transfer, drain to EMPTY when consumed without refill.
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      data_d  = data_q;
      carry_d = carry_q;
      id_d    = id_q;
      if (xfer) begin
         state_d = FULL;
         last_d  = gnt_idx;
         data_d  = alu_data;
         carry_d = alu_carry;
         id_d    = gnt_idx;
      end else if ((state_q == FULL) && out_ready) begin
         state_d = EMPTY;
      end
   end

   // State and output register; last resets to 1 so requester 0 wins the first tie.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= EMPTY;
         last_q  <= 1'b1;
         data_q  <= '0;
         carry_q <= 1'b0;
         id_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         data_q  <= data_d;
         carry_q <= carry_d;
         id_q    <= id_d;
      end
   end

   // Registered outputs.
   always_comb begin
      out_valid = (state_q == FULL);
      out_data  = data_q;
      out_carry = carry_q;
      out_id    = id_q;
   end

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed self-checking bench for addsub_arbiter (WIDTH = 8).
module tb_addsub_arbiter;

   localparam int unsigned W = 8;

   logic           clk;
   logic           rst;
   logic [1:0]     in_valid;
   logic [1:0]     in_ready;
   logic [2*W-1:0] in_a;
   logic [2*W-1:0] in_b;
   logic [1:0]     in_sel;
   logic           out_valid;
   logic           out_ready;
   logic [W-1:0]   out_data;
   logic           out_carry;
   logic           out_id;

   int n_checks = 0;
   int n_fail   = 0;

   addsub_arbiter #(
      .WIDTH (W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_sel    (in_sel),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_carry (out_carry),
      .out_id    (out_id)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled at the falling edge.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_req(input int idx, input logic [7:0] a, input logic [7:0] b,
                          input logic sel);
      in_a[idx*W +: W] = a;
      in_b[idx*W +: W] = b;
      in_sel[idx]      = sel;
      in_valid[idx]    = 1'b1;
   endtask

   // One isolated request with out_ready high; checks grant, result and drain.
   task automatic do_single(input string tag, input int idx, input logic [7:0] a,
                            input logic [7:0] b, input logic sel,
                            input logic [7:0] exp_data, input logic exp_carry);
      out_ready = 1'b1;
      set_req(idx, a, b, sel);
      #1;
      check_eq({tag, "_ready"}, 32'(in_ready), (idx == 0) ? 32'd1 : 32'd2);
      step();
      in_valid = 2'b00;
      check_eq({tag, "_valid"}, 32'(out_valid), 32'd1);
      check_eq({tag, "_data"},  32'(out_data),  32'(exp_data));
      check_eq({tag, "_carry"}, 32'(out_carry), 32'(exp_carry));
      check_eq({tag, "_id"},    32'(out_id),    32'(idx));
      step();
      check_eq({tag, "_drain"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 2'b11;
      in_a      = '0;
      in_b      = '0;
      in_sel    = 2'b00;
      out_ready = 1'b0;

      // Reset state.
      #2;
      check_eq("rst_out_valid", 32'(out_valid), 32'd0);
      check_eq("rst_out_data",  32'(out_data),  32'd0);
      check_eq("rst_out_carry", 32'(out_carry), 32'd0);
      check_eq("rst_out_id",    32'(out_id),    32'd0);
      check_eq("rst_in_ready",  32'(in_ready),  32'd0);
      @(negedge clk);
      rst      = 1'b0;
      in_valid = 2'b00;
      step();

      // Round-robin from reset: req0 1+1=2, req1 9-3=6, both held for 4 cycles.
      out_ready = 1'b1;
      set_req(0, 8'd1, 8'd1, 1'b1);
      set_req(1, 8'd9, 8'd3, 1'b0);
      for (int k = 0; k < 4; k++) begin
         #1;
         check_eq("rr_ready", 32'(in_ready), (k % 2 == 0) ? 32'd1 : 32'd2);
         step();
         check_eq("rr_id",   32'(out_id),   32'(k % 2));
         check_eq("rr_data", 32'(out_data), (k % 2 == 0) ? 32'd2 : 32'd6);
      end
      in_valid = 2'b00;
      step();
      check_eq("rr_drain", 32'(out_valid), 32'd0);

      // Back-pressure: req0 50+20=70 held in register while req1 (7-2=5) waits.
      out_ready = 1'b0;
      set_req(0, 8'd50, 8'd20, 1'b1);
      #1;
      check_eq("bp_ready0", 32'(in_ready), 32'd1);
      step();
      in_valid = 2'b00;
      set_req(1, 8'd7, 8'd2, 1'b0);
      for (int k = 0; k < 3; k++) begin
         #1;
         check_eq("bp_stall_ready", 32'(in_ready),  32'd0);
         check_eq("bp_stall_valid", 32'(out_valid), 32'd1);
         check_eq("bp_stall_data",  32'(out_data),  32'd70);
         step();
      end
      out_ready = 1'b1;
      #1;
      check_eq("bp_release_ready", 32'(in_ready), 32'd2);
      step();
      in_valid = 2'b00;
      check_eq("bp_next_id",   32'(out_id),   32'd1);
      check_eq("bp_next_data", 32'(out_data), 32'd5);
      step();
      check_eq("bp_drain", 32'(out_valid), 32'd0);

      // Reset mid-operation while FULL with req1 waiting.
      out_ready = 1'b0;
      set_req(0, 8'd1, 8'd2, 1'b1);
      step();
      in_valid = 2'b00;
      check_eq("mr_full", 32'(out_valid), 32'd1);
      set_req(1, 8'd4, 8'd4, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      check_eq("mr_valid_drop", 32'(out_valid), 32'd0);
      check_eq("mr_ready_low",  32'(in_ready),  32'd0);
      @(negedge clk);
      check_eq("mr_hold_valid", 32'(out_valid), 32'd0);
      rst       = 1'b0;
      out_ready = 1'b1;
      set_req(0, 8'd3, 8'd3, 1'b1);
      #1;
      check_eq("mr_tie_ready", 32'(in_ready), 32'd1);
      step();
      in_valid = 2'b00;
      check_eq("mr_tie_id",   32'(out_id),   32'd0);
      check_eq("mr_tie_data", 32'(out_data), 32'd6);
      step();

      // Single requests, including wrap and borrow.
      do_single("add3_4",    0, 8'd3,   8'd4,   1'b1, 8'd7,   1'b0);
      do_single("add200_100", 0, 8'd200, 8'd100, 1'b1, 8'd44,  1'b1);
      do_single("sub5_10",   1, 8'd5,   8'd10,  1'b0, 8'd251, 1'b1);
      do_single("sub10_5",   0, 8'd10,  8'd5,   1'b0, 8'd5,   1'b0);

      // Full throughput: 8 back-to-back adds i+i from req0.
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         set_req(0, 8'(i), 8'(i), 1'b1);
         #1;
         check_eq("tp_ready", 32'(in_ready), 32'd1);
         step();
         check_eq("tp_valid", 32'(out_valid), 32'd1);
         check_eq("tp_data",  32'(out_data),  32'(2 * i));
      end
      in_valid = 2'b00;
      step();
      check_eq("tp_drain", 32'(out_valid), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
